signed_rca6_adder: RTL and testbench

- 6-bit signed (two's complement) ripple-carry adder producing a full-precision 7-bit signed sum.
- Built hierarchically from a chain of one-bit full-adder cells; the result is captured in an output register.
- Arithmetic leaf for generated-arithmetic test circuits; feeds wider datapaths that need the un-truncated signed sum.

---
 rtl/s_rca6_pkg.sv | 8 +
 rtl/fa_cell.sv | 14 +
 rtl/signed_rca6_adder.sv | 76 +++++++
 tb/tb_signed_rca6_adder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/s_rca6_pkg.sv
// rtl/s_rca6_pkg.sv - shared widths and operand/sum types for the 6-bit signed ripple-carry adder
package s_rca6_pkg;
  localparam int RCA_W = 6;
  localparam int SUM_W = RCA_W + 1;

  typedef logic signed [RCA_W-1:0] operand_t;
  typedef logic signed [SUM_W-1:0] sum_t;
endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - one-bit full adder cell used as the ripple-chain element
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/signed_rca6_adder.sv
// rtl/signed_rca6_adder.sv - registered 6-bit signed ripple-carry adder, full 7-bit sum
// Optional registered overflow flag output ovf under macro S_RCA6_OVF_EN.
module signed_rca6_adder
  import s_rca6_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  operand_t a,
  input  operand_t b,
`ifdef S_RCA6_OVF_EN
  output logic     ovf,
`endif
  output sum_t     out,
  output logic     out_valid
);
  logic [RCA_W:0]   c;
  logic [RCA_W-1:0] s;
  sum_t             sum_c;
  sum_t             out_d, out_q;
  logic             vld_d, vld_q;

  // Bit 0 behaves as a half adder because its carry-in is tied low.
  assign c[0] = 1'b0;

  for (genvar i = 0; i < RCA_W; i++) begin : g_chain
    fa_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // Sign bit of the widened sum: sign-extend both operands, add the carry out.
  assign sum_c = {a[RCA_W-1] ^ b[RCA_W-1] ^ c[RCA_W], s};

  always_comb begin
    out_d = out_q;
    vld_d = 1'b0;
    if (in_valid) begin
      out_d = sum_c;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;

`ifdef S_RCA6_OVF_EN
  logic ovf_d, ovf_q;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = c[RCA_W-1] ^ c[RCA_W];
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_signed_rca6_adder.sv
// tb/tb_signed_rca6_adder.sv - scoreboard bench for signed_rca6_adder (random, directed, exhaustive)
module tb_signed_rca6_adder;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [5:0] a, b;
  logic [6:0] out;
  logic       out_valid;
`ifdef S_RCA6_OVF_EN
  logic       ovf;
`endif

  typedef struct {
    int due;
    int sum;
    bit ovf;
  } exp_t;

  exp_t q[$];
  int   cyc      = 0;
  int   checks   = 0;
  int   failures = 0;
  int   last_sum = 0;
  bit   mon_en   = 1'b0;

  signed_rca6_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
`ifdef S_RCA6_OVF_EN
    .ovf       (ovf),
`endif
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of stimulus just after the edge; record what the DUT owes us.
  task automatic issue(input bit r, input bit v, input logic [5:0] av, input logic [5:0] bv);
    exp_t e;
    int   sa, sb;
    @(posedge clk);
    #1;
    rst      = r;
    in_valid = v;
    a        = av;
    b        = bv;
    if (v && !r) begin
      sa     = $signed(av);
      sb     = $signed(bv);
      e.due  = cyc + 1;
      e.sum  = sa + sb;
      e.ovf  = (e.sum > 31) || (e.sum < -32);
      last_sum = e.sum;
      q.push_back(e);
    end else if (r) begin
      last_sum = 0;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        check("out_valid", int'(out_valid), 1);
        check("out", int'($signed(out)), e.sum);
`ifdef S_RCA6_OVF_EN
        check("ovf", int'(ovf), int'(e.ovf));
`endif
      end else begin
        check("out_valid_idle", int'(out_valid), 0);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 6'd5;
    b        = 6'd3;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_out", int'(out), 0);
      check("reset_out_valid", int'(out_valid), 0);
`ifdef S_RCA6_OVF_EN
      check("reset_ovf", int'(ovf), 0);
`endif
    end
    mon_en = 1'b1;
    issue(1'b0, 1'b0, 6'd5, 6'd3);
    @(negedge clk);
    check("post_reset_out", int'(out), 0);

    // Directed corners: positive overflow, both extremes, mixed signs, zero.
    issue(1'b0, 1'b1, 6'd20, 6'd28);
    issue(1'b0, 1'b1, 6'b100000, 6'b100000);
    issue(1'b0, 1'b1, 6'd31, 6'd31);
    issue(1'b0, 1'b1, 6'b111111, 6'd1);
    issue(1'b0, 1'b1, 6'b101100, 6'd7);

    // Reset mid-stream: the operand presented alongside reset is dropped.
    issue(1'b0, 1'b1, 6'd9, 6'd9);
    issue(1'b1, 1'b1, 6'd12, 6'd12);
    issue(1'b0, 1'b0, 6'd0, 6'd0);
    @(negedge clk);
    check("midreset_out", int'(out), 0);

    // Back-to-back stream then hold.
    for (int i = 0; i < 20; i++) begin
      logic [5:0] sa, sb;
      sa = 6'(20 + i);
      sb = 6'(28 + 2 * i);
      issue(1'b0, 1'b1, sa, sb);
    end
    issue(1'b0, 1'b0, 6'd1, 6'd1);
    issue(1'b0, 1'b0, 6'd2, 6'd2);
    @(negedge clk);
    check("hold_out", int'($signed(out)), last_sum);

    // Randomised traffic with gaps and occasional resets.
    for (int i = 0; i < 300; i++) begin
      bit r, v;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 3) != 0);
      issue(r, v, 6'($urandom), 6'($urandom));
    end
    issue(1'b0, 1'b0, 6'd0, 6'd0);

    // Exhaustive sweep.
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        issue(1'b0, 1'b1, 6'(i), 6'(j));
      end
    end
    issue(1'b0, 1'b0, 6'd0, 6'd0);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    check("scoreboard_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
